// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the mem_arbiter block.
package mem_arb_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 22;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  typedef enum logic [1:0] {
    CPU,
    PPU,
    LDR
  } req_id_e;

  // Address travels beside this struct because its width is a module parameter.
  typedef struct packed {
    logic       we;
    logic [7:0] wdata;
  } slot_t;

endpackage

// File: rtl/mem_arb_slot.sv
// One requester's pending slot: captures a request, tracks pending, flags overrun.
module mem_arb_slot
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [7:0]        wdata,
  input  logic              clr,
  output logic              pending,
  output logic [ADDR_W-1:0] slot_addr,
  output slot_t             slot,
  output logic              overrun
);

  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  slot_t             slot_q, slot_d;

  // A request landing on the completion edge is accepted: set wins over clear.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    addr_d    = addr_q;
    slot_d    = slot_q;
    if (clr) pending_d = 1'b0;
    if (req) begin
      if (!pending_q || clr) begin
        pending_d    = 1'b1;
        addr_d       = addr;
        slot_d.we    = we;
        slot_d.wdata = wdata;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      addr_q    <= '0;
      slot_q    <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      addr_q    <= addr_d;
      slot_q    <= slot_d;
    end
  end

  assign pending   = pending_q;
  assign overrun   = overrun_q;
  assign slot_addr = addr_q;
  assign slot      = slot_q;

endmodule

// File: rtl/mem_arbiter.sv
// CPU/PPU arbiter onto a single external byte memory with a bounded PPU streak.
// Define MEM_ARB_LOADER_EN to add a write-only, highest-priority loader requester.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEFAULT_ADDR_W,
  parameter int unsigned MAX_PPU_STREAK = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_done,
  input  logic              ppu_req,
  input  logic [ADDR_W-1:0] ppu_addr,
  input  logic              ppu_we,
  input  logic [7:0]        ppu_wdata,
  output logic [7:0]        ppu_rdata,
  output logic              ppu_done,
`ifdef MEM_ARB_LOADER_EN
  input  logic              ldr_req,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [7:0]        ldr_wdata,
  output logic              ldr_done,
`endif
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned STREAK_W = (MAX_PPU_STREAK == 0) ? 1 : $clog2(MAX_PPU_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_PPU_STREAK);

  state_e              state_q, state_d;
  req_id_e             winner_q, winner_d, pick;
  logic                pick_valid;
  logic [ADDR_W-1:0]   addr_q, addr_d, pick_addr;
  slot_t               meta_q, meta_d, pick_slot;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [7:0]          cpu_rdata_q, cpu_rdata_d, ppu_rdata_q, ppu_rdata_d;
  logic                cpu_done_q, ppu_done_q;

  logic              cpu_pend, ppu_pend, ldr_pend;
  logic [ADDR_W-1:0] cpu_saddr, ppu_saddr, ldr_saddr;
  slot_t             cpu_slot, ppu_slot, ldr_slot;
  logic              cpu_ovr, ppu_ovr, ldr_ovr;
  logic              ack_fire, cpu_clr, ppu_clr;

  assign ack_fire = mem_ack && (state_q != IDLE);
  assign cpu_clr  = ack_fire && (winner_q == CPU);
  assign ppu_clr  = ack_fire && (winner_q == PPU);

  mem_arb_slot #(.ADDR_W(ADDR_W)) u_cpu_slot (
    .clk(clk), .reset(reset), .req(cpu_req), .addr(cpu_addr), .we(cpu_we),
    .wdata(cpu_wdata), .clr(cpu_clr), .pending(cpu_pend), .slot_addr(cpu_saddr),
    .slot(cpu_slot), .overrun(cpu_ovr)
  );

  mem_arb_slot #(.ADDR_W(ADDR_W)) u_ppu_slot (
    .clk(clk), .reset(reset), .req(ppu_req), .addr(ppu_addr), .we(ppu_we),
    .wdata(ppu_wdata), .clr(ppu_clr), .pending(ppu_pend), .slot_addr(ppu_saddr),
    .slot(ppu_slot), .overrun(ppu_ovr)
  );

`ifdef MEM_ARB_LOADER_EN
  logic ldr_clr, ldr_done_q;
  assign ldr_clr = ack_fire && (winner_q == LDR);

  mem_arb_slot #(.ADDR_W(ADDR_W)) u_ldr_slot (
    .clk(clk), .reset(reset), .req(ldr_req), .addr(ldr_addr), .we(1'b1),
    .wdata(ldr_wdata), .clr(ldr_clr), .pending(ldr_pend), .slot_addr(ldr_saddr),
    .slot(ldr_slot), .overrun(ldr_ovr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ldr_done_q <= 1'b0;
    else        ldr_done_q <= ldr_clr;
  end

  assign ldr_done = ldr_done_q;
`else
  assign ldr_pend  = 1'b0;
  assign ldr_saddr = '0;
  assign ldr_slot  = '0;
  assign ldr_ovr   = 1'b0;
`endif

  // Loader first, then PPU unless a waiting CPU has sat out a full PPU streak.
  always_comb begin
    pick_valid = 1'b1;
    pick       = CPU;
    if (ldr_pend) begin
      pick = LDR;
    end else if (ppu_pend && !(cpu_pend && (streak_q == STREAK_MAX))) begin
      pick = PPU;
    end else if (!cpu_pend) begin
      pick_valid = 1'b0;
    end
    case (pick)
      PPU:     begin pick_addr = ppu_saddr; pick_slot = ppu_slot; end
      LDR:     begin pick_addr = ldr_saddr; pick_slot = ldr_slot; end
      default: begin pick_addr = cpu_saddr; pick_slot = cpu_slot; end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    addr_d   = addr_q;
    meta_d   = meta_q;
    streak_d = streak_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d  = ISSUE;
          winner_d = pick;
          addr_d   = pick_addr;
          meta_d   = pick_slot;
          if (pick == CPU) streak_d = '0;
          else if (pick == PPU && streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
        end
      end
      ISSUE:   state_d = mem_ack ? IDLE : WAIT;
      WAIT:    if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_rdata_d = cpu_rdata_q;
    ppu_rdata_d = ppu_rdata_q;
    if (cpu_clr && !meta_q.we) cpu_rdata_d = mem_rdata;
    if (ppu_clr && !meta_q.we) ppu_rdata_d = mem_rdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      winner_q    <= CPU;
      addr_q      <= '0;
      meta_q      <= '0;
      streak_q    <= '0;
      cpu_rdata_q <= '0;
      ppu_rdata_q <= '0;
      cpu_done_q  <= 1'b0;
      ppu_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      addr_q      <= addr_d;
      meta_q      <= meta_d;
      streak_q    <= streak_d;
      cpu_rdata_q <= cpu_rdata_d;
      ppu_rdata_q <= ppu_rdata_d;
      cpu_done_q  <= cpu_clr;
      ppu_done_q  <= ppu_clr;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign busy      = (state_q != IDLE);
  assign mem_addr  = addr_q;
  assign mem_we    = meta_q.we;
  assign mem_wdata = meta_q.wdata;
  assign cpu_rdata = cpu_rdata_q;
  assign ppu_rdata = ppu_rdata_q;
  assign cpu_done  = cpu_done_q;
  assign ppu_done  = ppu_done_q;
  assign overrun   = cpu_ovr | ppu_ovr | ldr_ovr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus
// hand-written sequences for priority, streak, overrun and reset corners.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 22;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cpu_req = 1'b0, cpu_we = 1'b0, cpu_done;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [7:0]        cpu_wdata = '0, cpu_rdata;
  logic              ppu_req = 1'b0, ppu_we = 1'b0, ppu_done;
  logic [ADDR_W-1:0] ppu_addr = '0;
  logic [7:0]        ppu_wdata = '0, ppu_rdata;
  logic              mem_req, mem_we, mem_ack = 1'b0, busy, overrun;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, mem_rdata = '0;
`ifdef MEM_ARB_LOADER_EN
  logic              ldr_req = 1'b0, ldr_done;
  logic [ADDR_W-1:0] ldr_addr = '0;
  logic [7:0]        ldr_wdata = '0;
  int unsigned       ldr_dn;
`endif

  mem_arbiter #(.ADDR_W(ADDR_W), .MAX_PPU_STREAK(2)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_we(ppu_we), .ppu_wdata(ppu_wdata),
    .ppu_rdata(ppu_rdata), .ppu_done(ppu_done),
`ifdef MEM_ARB_LOADER_EN
    .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_done(ldr_done),
`endif
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              is_ppu;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [7:0]        wdata;
    logic [7:0]        rdata;
    int unsigned       dly;
    logic [7:0]        exp_rd;
  } vec_t;

  int unsigned       total = 0;
  int unsigned       bad = 0;
  logic [ADDR_W-1:0] gq[$];
  logic              wq[$];
  int unsigned       cpu_dn, ppu_dn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Immediate-ack responder; every cycle with mem_req high is a distinct grant.
  task automatic tick_ack();
    tick();
    if (cpu_done) cpu_dn++;
    if (ppu_done) ppu_dn++;
`ifdef MEM_ARB_LOADER_EN
    if (ldr_done) ldr_dn++;
`endif
    if (mem_req) begin
      gq.push_back(mem_addr);
      wq.push_back(mem_we);
    end
    mem_ack = mem_req;
  endtask

  function automatic logic [31:0] gq_at(input int unsigned k);
    return (k < gq.size()) ? 32'(gq[k]) : 32'hFFFF_FFFF;
  endfunction

  task automatic clear_log();
    gq.delete();
    wq.delete();
    cpu_dn = 0;
    ppu_dn = 0;
`ifdef MEM_ARB_LOADER_EN
    ldr_dn = 0;
`endif
  endtask

  task automatic do_txn(input vec_t v, input int unsigned id);
    int unsigned lat = 0;
    int unsigned seen = 0;
    logic hit = 1'b0;
    logic other = 1'b0;
    if (v.is_ppu) begin
      ppu_req = 1'b1; ppu_addr = v.addr; ppu_we = v.we; ppu_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_addr = v.addr; cpu_we = v.we; cpu_wdata = v.wdata;
    end
    while (!hit && lat < 30) begin
      tick();
      lat++;
      cpu_req = 1'b0;
      ppu_req = 1'b0;
      if (v.is_ppu ? cpu_done : ppu_done) other = 1'b1;
      if (v.is_ppu ? ppu_done : cpu_done) begin
        hit = 1'b1;
      end else if (mem_req) begin
        if (seen == 0) begin
          chk($sformatf("v%0d_addr", id), 32'(mem_addr), 32'(v.addr));
          chk($sformatf("v%0d_we", id), 32'(mem_we), 32'(v.we));
          chk($sformatf("v%0d_wdata", id), 32'(mem_wdata), 32'(v.wdata));
        end
        mem_ack   = (seen == v.dly);
        mem_rdata = mem_ack ? v.rdata : 8'hEE;
        seen++;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'hEE;
      end
    end
    mem_ack = 1'b0;
    chk($sformatf("v%0d_latency", id), 32'(lat), 32'(3 + v.dly));
    chk($sformatf("v%0d_rdata", id), 32'(v.is_ppu ? ppu_rdata : cpu_rdata), 32'(v.exp_rd));
    chk($sformatf("v%0d_busy_at_done", id), 32'(busy), 32'd0);
    chk($sformatf("v%0d_other_done", id), 32'(other), 32'd0);
    tick();
    chk($sformatf("v%0d_done_width", id), 32'(v.is_ppu ? ppu_done : cpu_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    vec_t rv;
    int unsigned rereq;
    vecs[0] = '{1'b0, 22'h008000, 1'b0, 8'h00, 8'hA5, 0, 8'hA5};
    vecs[1] = '{1'b1, 22'h002000, 1'b0, 8'h00, 8'h3C, 2, 8'h3C};
    vecs[2] = '{1'b0, 22'h3FFFFF, 1'b1, 8'h5A, 8'h77, 1, 8'hA5};
    vecs[3] = '{1'b1, 22'h000000, 1'b1, 8'hFF, 8'h11, 0, 8'h3C};
    vecs[4] = '{1'b0, 22'h155555, 1'b0, 8'h00, 8'h00, 3, 8'h00};
    vecs[5] = '{1'b1, 22'h2AAAAA, 1'b0, 8'h00, 8'hFF, 0, 8'hFF};

    repeat (3) tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cpu_done", 32'(cpu_done), 32'd0);
    chk("rst_ppu_done", 32'(ppu_done), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_ppu_rdata", 32'(ppu_rdata), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    #2 reset = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) do_txn(vecs[i], i);

    // Simultaneous requests: PPU wins, CPU follows.
    clear_log();
    cpu_req = 1'b1; cpu_addr = 22'h001000; cpu_we = 1'b0;
    ppu_req = 1'b1; ppu_addr = 22'h002000; ppu_we = 1'b0;
    tick_ack();
    cpu_req = 1'b0; ppu_req = 1'b0;
    repeat (8) tick_ack();
    chk("prio_grants", 32'(gq.size()), 32'd2);
    chk("prio_first", gq_at(0), 32'h2000);
    chk("prio_second", gq_at(1), 32'h1000);
    chk("prio_cpu_done", 32'(cpu_dn), 32'd1);
    chk("prio_ppu_done", 32'(ppu_dn), 32'd1);

    // PPU re-requests on its ack edge while CPU waits: PPU, PPU, CPU, PPU.
    clear_log();
    rereq = 0;
    cpu_req = 1'b1; cpu_addr = 22'h001000;
    ppu_req = 1'b1; ppu_addr = 22'h002000;
    tick_ack();
    cpu_req = 1'b0; ppu_req = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick_ack();
      ppu_req = 1'b0;
      if (mem_req && rereq < 2) begin
        ppu_req  = 1'b1;
        ppu_addr = 22'h002001 + ADDR_W'(rereq);
        rereq++;
      end
    end
    chk("streak_grants", 32'(gq.size()), 32'd4);
    chk("streak_g0", gq_at(0), 32'h2000);
    chk("streak_g1", gq_at(1), 32'h2001);
    chk("streak_g2", gq_at(2), 32'h1000);
    chk("streak_g3", gq_at(3), 32'h2002);
    chk("streak_ppu_done", 32'(ppu_dn), 32'd3);
    chk("streak_no_overrun", 32'(overrun), 32'd0);

    // Second cpu_req while pending is dropped and sets the sticky flag.
    clear_log();
    cpu_req = 1'b1; cpu_addr = 22'h000ABC;
    tick_ack();
    cpu_addr = 22'h000DEF;
    tick_ack();
    cpu_req = 1'b0;
    repeat (8) tick_ack();
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_cpu_done", 32'(cpu_dn), 32'd1);
    chk("ovr_grants", 32'(gq.size()), 32'd1);
    chk("ovr_addr", gq_at(0), 32'h0ABC);

    // Reset in WAIT with ack withheld.
    cpu_req = 1'b1; cpu_addr = 22'h000777; cpu_we = 1'b0;
    tick();
    cpu_req = 1'b0;
    tick();
    tick();
    chk("rw_in_wait", 32'(mem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rw_mem_req", 32'(mem_req), 32'd0);
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_overrun_clr", 32'(overrun), 32'd0);
    clear_log();
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cpu_done) cpu_dn++;
    end
    mem_ack = 1'b0;
    chk("rw_no_done", 32'(cpu_dn), 32'd0);
    chk("rw_rdata_clr", 32'(cpu_rdata), 32'd0);
    #2 reset = 1'b1;
    clear_log();
    repeat (4) tick_ack();
    chk("rw_no_stale_grant", 32'(gq.size()), 32'd0);
    rv = '{1'b0, 22'h000777, 1'b0, 8'h00, 8'h42, 1, 8'h42};
    do_txn(rv, 6);

`ifdef MEM_ARB_LOADER_EN
    // Loader first and outside the PPU streak: LDR, PPU, PPU, CPU, PPU.
    clear_log();
    rereq = 0;
    ldr_req = 1'b1; ldr_addr = 22'h003000; ldr_wdata = 8'h99;
    cpu_req = 1'b1; cpu_addr = 22'h001000;
    ppu_req = 1'b1; ppu_addr = 22'h002000;
    tick_ack();
    ldr_req = 1'b0; cpu_req = 1'b0; ppu_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick_ack();
      ppu_req = 1'b0;
      if (mem_req && mem_addr[15:12] == 4'h2 && rereq < 2) begin
        ppu_req  = 1'b1;
        ppu_addr = 22'h002001 + ADDR_W'(rereq);
        rereq++;
      end
    end
    chk("ldr_grants", 32'(gq.size()), 32'd5);
    chk("ldr_g0", gq_at(0), 32'h3000);
    chk("ldr_we", 32'((wq.size() > 0) ? wq[0] : 1'b0), 32'd1);
    chk("ldr_g1", gq_at(1), 32'h2000);
    chk("ldr_g2", gq_at(2), 32'h2001);
    chk("ldr_g3", gq_at(3), 32'h1000);
    chk("ldr_g4", gq_at(4), 32'h2002);
    chk("ldr_done_cnt", 32'(ldr_dn), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
